// File: rtl/sad_window_gen.sv
// Streaming WIN x WIN window generator for the SAD datapath.
// Optional centre coordinate outputs: define SAD_WINGEN_COORD_EN.
module sad_window_gen #(
    parameter int WIN        = 15,
    parameter int DATA_SIZE  = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48,
    parameter int WIN_SIZE   = WIN * WIN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_SIZE-1:0]          pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic                          sof,
    output logic [DATA_SIZE*WIN_SIZE-1:0] window_out,
    output logic                          window_valid,
    input  logic                          window_ready,
    output logic                          frame_done
`ifdef SAD_WINGEN_COORD_EN
    ,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(WIN - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          wv_q, wv_d;
    logic          fd_q, fd_d;

    logic [DATA_SIZE*WIN_SIZE-1:0] win_q, win_d;
    logic [DATA_SIZE-1:0] lb_q [WIN-1][IMG_WIDTH];
    logic [DATA_SIZE-1:0] col_in [WIN];

    logic          accept;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;
    logic          line_end;
    logic          frame_end;
    logic          qualify;

    // sof forces the accepted pixel to (0,0) whatever the counters say
    assign pix_ready = ~wv_q | window_ready;
    assign accept    = pix_valid & pix_ready;
    assign eff_col   = sof ? '0 : col_q;
    assign eff_row   = sof ? '0 : row_q;
    assign line_end  = (eff_col == COL_LAST);
    assign frame_end = line_end && (eff_row == ROW_LAST);
    assign qualify   = (eff_row >= ROW_WIN) && (eff_col >= COL_WIN);

    // raster counters, window valid and frame-done next state
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        wv_d  = wv_q;
        fd_d  = 1'b0;
        if (accept) begin
            wv_d = qualify;
            fd_d = frame_end;
            if (line_end) begin
                col_d = '0;
                row_d = frame_end ? '0 : eff_row + RW'(1);
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end
        end else if (window_ready) begin
            wv_d = 1'b0;
        end
    end

    // new window column: oldest line on top, incoming pixel at the bottom
    always_comb begin
        col_in[WIN-1] = pix_in;
        for (int r = 0; r < WIN - 1; r++) begin
            col_in[r] = lb_q[WIN-2-r][eff_col];
        end
    end

    // shift the window left by one column and append the new column
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_d[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] =
                        win_q[DATA_SIZE*(r*WIN+c+1) +: DATA_SIZE];
                end
                win_d[DATA_SIZE*(r*WIN+WIN-1) +: DATA_SIZE] = col_in[r];
            end
        end
    end

    // control state, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            wv_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            wv_q  <= wv_d;
            fd_q  <= fd_d;
        end
    end

    // pixel storage; left unreset since the counters gate its use
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (accept) begin
            for (int i = 1; i < WIN - 1; i++) begin
                lb_q[i][eff_col] <= lb_q[i-1][eff_col];
            end
            lb_q[0][eff_col] <= pix_in;
        end
    end

    assign window_out   = win_q;
    assign window_valid = wv_q;
    assign frame_done   = fd_q;

`ifdef SAD_WINGEN_COORD_EN
    localparam logic [RW-1:0] HALF_R = RW'((WIN - 1) / 2);
    localparam logic [CW-1:0] HALF_C = CW'((WIN - 1) / 2);

    logic [RW-1:0] wrow_q, wrow_d;
    logic [CW-1:0] wcol_q, wcol_d;

    // centre coordinates follow the window register
    always_comb begin
        wrow_d = wrow_q;
        wcol_d = wcol_q;
        if (accept && qualify) begin
            wrow_d = eff_row - HALF_R;
            wcol_d = eff_col - HALF_C;
        end
    end

    // coordinate registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrow_q <= '0;
            wcol_q <= '0;
        end else begin
            wrow_q <= wrow_d;
            wcol_q <= wcol_d;
        end
    end

    assign win_row = wrow_q;
    assign win_col = wcol_q;
`endif

endmodule

// File: tb/tb_sad_window_gen.sv
// Scoreboard bench for sad_window_gen, WIN=3 on a 5x4 frame.
// Pixel value = row*16 + col.
module tb_sad_window_gen;

    localparam int WIN = 3;
    localparam int DW  = 8;
    localparam int W   = 5;
    localparam int H   = 4;
    localparam int WS  = WIN * WIN;
    localparam int WB  = DW * WS;

    localparam logic [WB-1:0] FIRST_WIN =
        {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16, 8'd2, 8'd1, 8'd0};
    localparam logic [WB-1:0] LAST_WIN =
        {8'd52, 8'd51, 8'd50, 8'd36, 8'd35, 8'd34, 8'd20, 8'd19, 8'd18};
    localparam logic [WB-1:0] BP2_WIN =
        {8'd35, 8'd34, 8'd33, 8'd19, 8'd18, 8'd17, 8'd3, 8'd2, 8'd1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic          sof;
    logic [WB-1:0] window_out;
    logic          window_valid;
    logic          window_ready;
    logic          frame_done;
`ifdef SAD_WINGEN_COORD_EN
    logic [1:0]    win_row;
    logic [2:0]    win_col;
`endif

    sad_window_gen #(
        .WIN(WIN),
        .DATA_SIZE(DW),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .sof(sof),
        .window_out(window_out),
        .window_valid(window_valid),
        .window_ready(window_ready),
        .frame_done(frame_done)
`ifdef SAD_WINGEN_COORD_EN
        ,
        .win_row(win_row),
        .win_col(win_col)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WB-1:0] w;
        int            r;
        int            c;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [WB-1:0] got_q[$];
    int            got_r[$];
    int            got_c[$];
    int            checks = 0;
    int            errors = 0;
    int            brow = 0;
    int            bcol = 0;
    int            fd_cnt = 0;
    bit            stall_prev = 1'b0;
    logic [WB-1:0] stall_w;

    task automatic check_win(input string name, input logic [WB-1:0] act,
                             input logic [WB-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [WB-1:0] model_win(input int r, input int c);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                w[DW*(i*WIN+j) +: DW] = DW'((r - WIN + 1 + i) * 16 + (c - WIN + 1 + j));
            end
        end
        return w;
    endfunction

    // monitor: pop and compare on every window handshake
    always @(negedge clk) begin
        if (rst_n && stall_prev) begin
            check_win("stall_hold", window_out, stall_w);
        end
        stall_prev = rst_n && window_valid && !window_ready;
        stall_w    = window_out;
        if (rst_n && frame_done) begin
            fd_cnt++;
        end
        if (rst_n && window_valid && window_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got %0h required none", window_out);
            end else begin
                e = exp_q.pop_front();
                check_win("window", window_out, e.w);
`ifdef SAD_WINGEN_COORD_EN
                check_int("win_row", int'(win_row), e.r);
                check_int("win_col", int'(win_col), e.c);
                got_r.push_back(int'(win_row));
                got_c.push_back(int'(win_col));
`endif
                got_q.push_back(window_out);
            end
        end
    end

    task automatic send_pixel(input bit s);
        int n;
        int er;
        int ec;
        bit qual;
        er        = s ? 0 : brow;
        ec        = s ? 0 : bcol;
        pix_in    = DW'(er * 16 + ec);
        sof       = s;
        pix_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pix_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!pix_ready) begin
            check_int("accept_timeout", 0, 1);
            pix_valid = 1'b0;
            sof       = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
        qual = (er >= WIN - 1) && (ec >= WIN - 1);
        if (qual) begin
            exp_q.push_back('{model_win(er, ec), er - 1, ec - 1});
        end
        check_int("valid_after_pixel", int'(window_valid), int'(qual));
        check_int("frame_done_pulse", int'(frame_done),
                  int'(er == H - 1 && ec == W - 1));
        if (ec == W - 1) begin
            bcol = 0;
            brow = (er == H - 1) ? 0 : er + 1;
        end else begin
            bcol = ec + 1;
            brow = er;
        end
    endtask

    task automatic do_stall();
        logic [WB-1:0] snap;
        snap         = window_out;
        window_ready = 1'b0;
        pix_in       = DW'(brow * 16 + bcol);
        pix_valid    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_int("bp_pix_ready", int'(pix_ready), 0);
            check_int("bp_valid", int'(window_valid), 1);
            check_win("bp_hold", window_out, snap);
            @(posedge clk);
            #1;
        end
        window_ready = 1'b1;
    endtask

    task automatic send_frame(input int stall_at, input bit use_sof);
        for (int i = 0; i < W * H; i++) begin
            send_pixel(use_sof && i == 0);
            if (i == stall_at) begin
                do_stall();
            end
        end
    endtask

    task automatic finish_frame();
        repeat (3) @(negedge clk);
        check_int("drain", exp_q.size(), 0);
        check_int("win_count", got_q.size(), (W - WIN + 1) * (H - WIN + 1));
        check_int("frame_done_count", fd_cnt, 1);
        if (got_q.size() >= 2) begin
            check_win("first_window", got_q[0], FIRST_WIN);
            check_win("last_window", got_q[got_q.size()-1], LAST_WIN);
        end
    endtask

    task automatic clear_frame();
        got_q.delete();
        got_r.delete();
        got_c.delete();
        fd_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        pix_in       = '0;
        pix_valid    = 1'b0;
        sof          = 1'b0;
        window_ready = 1'b0;
        #12;
        check_int("reset_valid", int'(window_valid), 0);
        check_int("reset_frame_done", int'(frame_done), 0);
        check_int("reset_pix_ready", int'(pix_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_int("release_pix_ready", int'(pix_ready), 1);
        window_ready = 1'b1;
        @(posedge clk);
        #1;

        // plain frame
        send_frame(-1, 1'b1);
        finish_frame();
`ifdef SAD_WINGEN_COORD_EN
        if (got_r.size() >= 2) begin
            check_int("first_row", got_r[0], 1);
            check_int("first_col", got_c[0], 1);
            check_int("last_row", got_r[got_r.size()-1], 2);
            check_int("last_col", got_c[got_c.size()-1], 3);
        end
`endif
        clear_frame();

        // backpressure on the first window
        @(posedge clk);
        #1;
        send_frame(12, 1'b1);
        finish_frame();
        if (got_q.size() >= 2) begin
            check_win("bp_second_window", got_q[1], BP2_WIN);
        end
        clear_frame();

        // sof resync after a partial frame
        for (int i = 0; i < 7; i++) begin
            send_pixel(i == 0);
        end
        send_frame(-1, 1'b1);
        finish_frame();
        clear_frame();

        // reset with a window pending, then a frame without sof
        for (int i = 0; i < 13; i++) begin
            send_pixel(i == 0);
        end
        #1 rst_n = 1'b0;
        #1;
        check_int("midreset_valid", int'(window_valid), 0);
        check_int("midreset_frame_done", int'(frame_done), 0);
        exp_q.delete();
        clear_frame();
        brow = 0;
        bcol = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(-1, 1'b0);
        finish_frame();
        clear_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
